demux_rr_driver: RTL and testbench
==================================

DEMUX_RR_DRIVER -- requirements
Module: demux_rr_driver

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1, giving the number of idle gap cycles after each drive cycle (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream data item present.
REQ-005 The block SHALL have port in_data, input, 1 bit: upstream data bit.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept an item this cycle.
REQ-007 The block SHALL have port en_mask, input, 4 bits: per-channel enable; present only when DEMUX_SKIP_EN is defined.
REQ-008 The block SHALL have port Din, output, 1 bit: data driven to the downstream 1x4 demux.
REQ-009 The block SHALL have port S, output, 2 bits: channel select driven to the downstream 1x4 demux.
REQ-010 The block SHALL have port out_strobe, output, 1 bit: Din/S carry a valid item this cycle.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the highest enabled channel is served.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DRIVE and HOLD.
REQ-013 in_ready SHALL be 1 only in IDLE with at least one enabled channel; otherwise it SHALL be 0.
REQ-014 An item is accepted on a rising edge where in_valid=1 and in_ready=1; IDLE->DRIVE SHALL occur on that edge, and IDLE SHALL persist otherwise.
REQ-015 On accept, the block SHALL register S = the first enabled channel at or after pointer ptr (cyclic search 0..3), register Din = in_data, and update ptr = (S+1) mod 4.
REQ-016 Latency SHALL be exactly one cycle: an item accepted at edge N is presented on Din/S with out_strobe=1 during the cycle following edge N.
REQ-017 DRIVE SHALL last exactly one cycle, then go to HOLD if HOLD_CYCLES>0, else to IDLE.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles, counted by a 4-bit down-counter, then return to IDLE.
REQ-019 In IDLE and HOLD, Din and out_strobe SHALL be 0, so every downstream Y output is 0; S SHALL keep its last value.
REQ-020 frame_done SHALL be 1 during a DRIVE cycle whose S equals the highest-index enabled channel, and 0 otherwise.
REQ-021 en_mask SHALL be sampled only at the accept edge; mask changes during DRIVE or HOLD SHALL NOT affect the item in flight.
REQ-022 If en_mask=4'b0000, in_ready SHALL stay 0 and ptr SHALL hold.
REQ-023 ptr SHALL wrap from 3 to 0 with no extra cycle.
REQ-024 Maximum throughput SHALL be one item per (2+HOLD_CYCLES) cycles.

Reset
REQ-025 While rst_n=0, regardless of clk, the state SHALL be IDLE, ptr=0, the hold counter=0, Din=0, S=2'b00, out_strobe=0 and frame_done=0.
REQ-026 Assertion of reset during DRIVE or HOLD SHALL discard the in-flight item; no strobe SHALL follow the release of reset.
REQ-027 After reset is released, in_ready SHALL be valid on the first clock edge.

Configuration
REQ-028 Macro DEMUX_SKIP_EN SHALL control the mask feature: when defined, the en_mask port exists and REQ-015, REQ-020 and REQ-022 use it.
REQ-029 When DEMUX_SKIP_EN is undefined, the en_mask port SHALL be absent and the mask SHALL be treated internally as 4'b1111, giving strict round-robin order 0,1,2,3,0...

Verification
REQ-030 Reset with HOLD_CYCLES=1, then four back-to-back items with data 1,0,1,1 -> strobes carry S=0,1,2,3 and Din=1,0,1,1; consecutive strobes are 3 cycles apart; frame_done fires with S=3.
REQ-031 HOLD_CYCLES=0, in_valid held 1 -> in_ready alternates 1/0; one strobe every 2 cycles; S wraps 3->0.
REQ-032 DEMUX_SKIP_EN defined, en_mask=4'b1010, 4 items -> S sequence 1,3,1,3; frame_done fires on each S=3.
REQ-033 DEMUX_SKIP_EN defined, en_mask=4'b0000, in_valid=1 for 10 cycles -> in_ready=0 and no strobes; en_mask set to 4'b0100 -> next strobe has S=2.
REQ-034 rst_n pulled low during HOLD after an item with S=2 -> outputs are 0 immediately; after release, the first item goes to S=0.
REQ-035 en_mask changed from 4'b1111 to 4'b0001 during HOLD -> the in-flight item is unaffected; the next item goes to S=0.

Source files
------------

// File: rtl/demux_rr_driver.sv
// Round-robin driver for a downstream 1x4 demux: one item per (2+HOLD_CYCLES) cycles.
// Define DEMUX_SKIP_EN to add the en_mask port; otherwise all four channels are always enabled.
module demux_rr_driver #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
`ifdef DEMUX_SKIP_EN
    input  logic [3:0] en_mask,
`endif
    output logic       Din,
    output logic [1:0] S,
    output logic       out_strobe,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
    localparam bit         HAS_HOLD  = (HOLD_CYCLES > 0);

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [3:0] hold_cnt;
    logic [3:0] mask;
    logic       accept;
    logic [1:0] sel, idx, last;
    logic       found;
    logic       sel_is_last;

`ifdef DEMUX_SKIP_EN
    assign mask = en_mask;
`else
    assign mask = 4'b1111;
`endif

    assign in_ready = (state == IDLE) && (|mask);
    assign accept   = in_valid && in_ready;

    // Cyclic search from ptr for the first enabled channel, plus the highest enabled index.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        last  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) last = 2'(i);
        end
        sel_is_last = (sel == last);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   state_nxt = HAS_HOLD ? HOLD : IDLE;
            HOLD:    if (hold_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Outputs are registered at the accept edge; the mask is not looked at again until the next accept.
    // NOTE: every register here is a flop with an async reset value; there is no storage array to leave unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 2'd0;
            hold_cnt   <= 4'd0;
            Din        <= 1'b0;
            S          <= 2'd0;
            out_strobe <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_strobe <= accept;
            Din        <= accept && in_data;
            frame_done <= accept && sel_is_last;
            if (accept) begin
                S   <= sel;
                ptr <= sel + 2'd1;
            end
            if (state == DRIVE) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_driver.sv
// Bench for demux_rr_driver: instance 1 has HOLD_CYCLES=1, instance 0 has HOLD_CYCLES=0.
// A cycle-level behavioural model is compared every cycle; directed tests pin strobe sequences with literals.
module tb_demux_rr_driver;

    typedef struct {
        int s;
        int d;
        int f;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v   [2];
    logic       d   [2];
    logic [3:0] m   [2];
    logic       rdy [2];
    logic       din [2];
    logic       st  [2];
    logic       fd  [2];
    logic [1:0] s   [2];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int hold_of [2] = '{0, 1};
    int busy    [2] = '{0, 0};
    int mptr    [2] = '{0, 0};
    int e_st    [2] = '{0, 0};
    int e_din   [2] = '{0, 0};
    int e_fd    [2] = '{0, 0};
    int e_s     [2] = '{0, 0};

    ev_t log0[$];
    ev_t log1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    demux_rr_driver #(.HOLD_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_data(d[0]), .in_ready(rdy[0]),
`ifdef DEMUX_SKIP_EN
        .en_mask(m[0]),
`endif
        .Din(din[0]), .S(s[0]), .out_strobe(st[0]), .frame_done(fd[0])
    );

    demux_rr_driver #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_data(d[1]), .in_ready(rdy[1]),
`ifdef DEMUX_SKIP_EN
        .en_mask(m[1]),
`endif
        .Din(din[1]), .S(s[1]), .out_strobe(st[1]), .frame_done(fd[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [3:0] mask_of(input int k);
`ifdef DEMUX_SKIP_EN
        return m[k];
`else
        return 4'b1111;
`endif
    endfunction

    // Model: an item is taken when idle with any channel enabled; it is shown for one cycle,
    // then the block is busy for HOLD_CYCLES more cycles.
    task automatic model_step(input int k);
        logic [3:0] mk;
        int ch;
        int top;
        mk = mask_of(k);
        if (busy[k] == 0 && mk != 4'd0 && v[k]) begin
            ch = -1;
            for (int i = 0; i < 4; i++)
                if (ch < 0 && mk[(mptr[k] + i) % 4]) ch = (mptr[k] + i) % 4;
            top = 0;
            for (int i = 0; i < 4; i++)
                if (mk[i]) top = i;
            e_st[k]  = 1;
            e_s[k]   = ch;
            e_din[k] = int'(d[k]);
            e_fd[k]  = (ch == top) ? 1 : 0;
            busy[k]  = 1 + hold_of[k];
            mptr[k]  = (ch + 1) % 4;
        end else begin
            e_st[k]  = 0;
            e_din[k] = 0;
            e_fd[k]  = 0;
            if (busy[k] > 0) busy[k]--;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy[k] = 0; mptr[k] = 0; e_st[k] = 0; e_din[k] = 0; e_fd[k] = 0; e_s[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    // Compare and monitor, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int act;
            int exp;
            int er;
            er  = (busy[k] == 0 && mask_of(k) != 4'd0) ? 1 : 0;
            act = {26'd0, rdy[k], st[k], s[k], din[k], fd[k]};
            exp = (er << 5) | (e_st[k] << 4) | (e_s[k] << 2) | (e_din[k] << 1) | e_fd[k];
            check($sformatf("dut%0d_rdy_stb_s_din_fd", k), act, exp);
            if (st[k]) begin
                ev_t e;
                e.s = int'(s[k]); e.d = int'(din[k]); e.f = int'(fd[k]); e.cyc = cyc;
                if (k == 0) log0.push_back(e);
                else        log1.push_back(e);
            end
        end
    end

    task automatic send(input int k, input logic bit_v);
        bit done;
        done = 1'b0;
        v[k] = 1'b1;
        d[k] = bit_v;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (rdy[k]) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int exp_d [4] = '{1, 0, 1, 1};
        int rp    [10];
        v[0] = 1'b0; v[1] = 1'b0; d[0] = 1'b0; d[1] = 1'b0;
        m[0] = 4'b1111; m[1] = 4'b1111;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", int'(st[1]), 0);
        check("rst_s", int'(s[1]), 0);
        check("rst_din", int'(din[1]), 0);
        check("rst_frame", int'(fd[1]), 0);
        check("rst_ready", int'(rdy[1]), 1);
        rst_n = 1'b1;

        // HOLD_CYCLES=1, four back-to-back items 1,0,1,1
        base = log1.size();
        for (int i = 0; i < 4; i++) send(1, exp_d[i][0]);
        v[1] = 1'b0;
        settle();
        check("rr4_count", log1.size() - base, 4);
        if (log1.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr4_s%0d", i), log1[base+i].s, i);
                check($sformatf("rr4_din%0d", i), log1[base+i].d, exp_d[i]);
                check($sformatf("rr4_frame%0d", i), log1[base+i].f, (i == 3) ? 1 : 0);
                if (i > 0) check($sformatf("rr4_gap%0d", i), log1[base+i].cyc - log1[base+i-1].cyc, 3);
            end
        end

        // HOLD_CYCLES=0, in_valid held: ready alternates, strobe every 2 cycles, S wraps
        base = log0.size();
        v[0] = 1'b1;
        d[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            rp[n] = int'(rdy[0]);
        end
        v[0] = 1'b0;
        settle();
        for (int n = 0; n < 10; n++) check($sformatf("h0_ready%0d", n), rp[n], (n % 2 == 0) ? 1 : 0);
        check("h0_count", log0.size() - base, 5);
        if (log0.size() - base == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("h0_s%0d", i), log0[base+i].s, i % 4);
                if (i > 0) check($sformatf("h0_gap%0d", i), log0[base+i].cyc - log0[base+i-1].cyc, 2);
            end
        end

        // Reset during HOLD after an item with S=2
        send(1, 1'b0);
        send(1, 1'b1);
        send(1, 1'b1);
        v[1] = 1'b0;
        @(posedge clk);
        #2;
        check("hold_s_kept", int'(s[1]), 2);
        check("hold_strobe", int'(st[1]), 0);
        base = log1.size();
        rst_n = 1'b0;
        #1;
        check("midrst_s", int'(s[1]), 0);
        check("midrst_din", int'(din[1]), 0);
        check("midrst_strobe", int'(st[1]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1, 1'b1);
        v[1] = 1'b0;
        settle();
        check("postrst_count", log1.size() - base, 1);
        if (log1.size() - base == 1) check("postrst_s", log1[base].s, 0);

`ifdef DEMUX_SKIP_EN
        // Mask 1010 -> S 1,3,1,3, frame on each
        pulse_reset();
        m[1] = 4'b1010;
        base = log1.size();
        for (int i = 0; i < 4; i++) send(1, 1'b1);
        v[1] = 1'b0;
        settle();
        check("m1010_count", log1.size() - base, 4);
        if (log1.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("m1010_s%0d", i), log1[base+i].s, (i % 2 == 0) ? 1 : 3);
                check($sformatf("m1010_frame%0d", i), log1[base+i].f, (i % 2 == 0) ? 0 : 1);
            end
        end

        // Empty mask blocks; then 0100 -> S=2
        m[1] = 4'b0000;
        v[1] = 1'b1;
        base = log1.size();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check($sformatf("m0_ready%0d", n), int'(rdy[1]), 0);
        end
        @(posedge clk);
        #1;
        check("m0_no_strobe", log1.size() - base, 0);
        m[1] = 4'b0100;
        send(1, 1'b1);
        v[1] = 1'b0;
        settle();
        check("m0100_count", log1.size() - base, 1);
        if (log1.size() - base == 1) check("m0100_s", log1[base].s, 2);

        // Mask change while an item is in flight does not affect it
        m[1] = 4'b1111;
        base = log1.size();
        send(1, 1'b1);
        m[1] = 4'b0001;
        v[1] = 1'b0;
        @(posedge clk);
        #1;
        m[1] = 4'b0001;
        settle();
        send(1, 1'b0);
        v[1] = 1'b0;
        settle();
        check("mchg_count", log1.size() - base, 2);
        if (log1.size() - base == 2) begin
            check("mchg_inflight_s", log1[base].s, 3);
            check("mchg_inflight_frame", log1[base].f, 1);
            check("mchg_next_s", log1[base+1].s, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
